// File: rtl/eth_mdio_ctrl_if.sv
// Host-side request/response bundle for the MDIO management controller.
// Ports: req_* (valid/ready request with fields), rsp_* completion, busy_o.
interface eth_mdio_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [4:0]  req_phy_addr_i;
    logic [4:0]  req_reg_addr_i;
    logic [15:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        busy_o;

    modport master (
        output req_valid_i, req_write_i, req_phy_addr_i,
        output req_reg_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  rsp_error_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_phy_addr_i,
        input  req_reg_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output rsp_error_o, busy_o
    );
endinterface

// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO management master: one read/write frame per request.
// Ports: clk_i, rst_ni (sync, active-low), host (request/response bundle),
//        mdc_o, mdio_o, mdio_oe_o (PHY pins), mdio_i (pre-synchronised input).
module eth_mdio_ctrl #(
    parameter int CLK_DIV       = 50,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    eth_mdio_ctrl_if.slave host,
    output logic mdc_o,
    output logic mdio_o,
    output logic mdio_oe_o,
    input  logic mdio_i
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam bit         HAS_PRE  = (PREAMBLE_BITS > 0);
    localparam logic [5:0] PRE_LAST =
        6'(HAS_PRE ? PREAMBLE_BITS - 1 : 0);

    state_t      state_q, state_d, nxt;
    logic [7:0]  div_q, div_d;
    logic [5:0]  cnt_q, cnt_d, len_m1;
    logic        mdc_d, mdio_d, oe_d;
    logic [31:0] sh_q, sh_d, frame;
    logic        wr_q, wr_d;
    logic [15:0] rx_q, rx_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        active, tick, rise, bit_end;

    assign active  = (state_q inside {PRE, HDR, TA, DATA});
    assign tick    = active && (div_q == DIV_LAST);
    assign rise    = tick && !mdc_o;
    assign bit_end = tick && mdc_o;

    // Everything after the preamble; read frames fill TA/data with
    // idle '1's because the line is released there anyway.
    assign frame = {2'b01,
                    host.req_write_i ? 2'b01 : 2'b10,
                    host.req_phy_addr_i,
                    host.req_reg_addr_i,
                    host.req_write_i ? {2'b10, host.req_wdata_i}
                                     : 18'h3FFFF};

    always_comb begin
        state_d  = state_q;
        nxt      = state_q;
        len_m1   = '0;
        cnt_d    = cnt_q;
        div_d    = '0;
        mdc_d    = mdc_o;
        mdio_d   = mdio_o;
        oe_d     = mdio_oe_o;
        sh_d     = sh_q;
        wr_d     = wr_q;
        rx_d     = rx_q;
        ta_err_d = ta_err_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        if (active) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
            if (tick) mdc_d = ~mdc_o;
        end

        unique case (state_q)
            PRE:  begin len_m1 = PRE_LAST; nxt = HDR;  end
            HDR:  begin len_m1 = 6'd13;    nxt = TA;   end
            TA:   begin len_m1 = 6'd1;     nxt = DATA; end
            DATA: begin len_m1 = 6'd15;    nxt = DONE; end
            default: begin end
        endcase

        if (state_q == IDLE && host.req_valid_i) begin
            wr_d     = host.req_write_i;
            ta_err_d = 1'b0;
            rx_d     = '0;
            cnt_d    = '0;
            oe_d     = 1'b1;
            if (HAS_PRE) begin
                state_d = PRE;
                mdio_d  = 1'b1;
                sh_d    = frame;
            end else begin
                state_d = HDR;
                mdio_d  = frame[31];
                sh_d    = {frame[30:0], 1'b0};
            end
        end

        if (state_q == DONE) state_d = IDLE;

        // Bit boundary: falling MDC, next bit goes on the line now.
        if (bit_end) begin
            if (cnt_q == len_m1) begin
                state_d = nxt;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
            unique case (state_d)
                PRE: begin
                    mdio_d = 1'b1;
                    oe_d   = 1'b1;
                end
                DONE: begin
                    mdio_d  = 1'b1;
                    oe_d    = 1'b0;
                    rdata_d = wr_q ? 16'h0000 : rx_q;
                    err_d   = wr_q ? 1'b0 : ta_err_q;
                end
                default: begin
                    mdio_d = sh_q[31];
                    sh_d   = {sh_q[30:0], 1'b0};
                    oe_d   = (state_d == HDR) || wr_q;
                end
            endcase
        end

        // Reads sample on the clk_i cycle MDC rises.
        if (rise && !wr_q) begin
            if (state_q == TA && cnt_q == 6'd1) ta_err_d = mdio_i;
            if (state_q == DATA) rx_d = {rx_q[14:0], mdio_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            mdc_o     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b0;
            sh_q      <= '0;
            wr_q      <= 1'b0;
            rx_q      <= '0;
            ta_err_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            mdc_o     <= mdc_d;
            mdio_o    <= mdio_d;
            mdio_oe_o <= oe_d;
            sh_q      <= sh_d;
            wr_q      <= wr_d;
            rx_q      <= rx_d;
            ta_err_q  <= ta_err_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign host.req_ready_o = (state_q == IDLE);
    assign host.rsp_valid_o = (state_q == DONE);
    assign host.busy_o      = (state_q != IDLE);
    assign host.rsp_rdata_o = rdata_q;
    assign host.rsp_error_o = err_q;

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Self-checking bench for eth_mdio_ctrl: two instances (long preamble, none).
// Ports: none; drives host interfaces and models a PHY on each MDIO pin set.
module tb_eth_mdio_ctrl;

    localparam int DA = 2;
    localparam int PA = 32;
    localparam int DB = 1;
    localparam int PB = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    eth_mdio_ctrl_if ha();
    eth_mdio_ctrl_if hb();

    logic mdc_a, mdio_a, oe_a;
    logic mdc_b, mdio_b, oe_b;
    logic mdi_a = 1'b1;
    logic mdi_b = 1'b1;

    int pass_cnt = 0;
    int total = 0;

    eth_mdio_ctrl #(.CLK_DIV(DA), .PREAMBLE_BITS(PA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .host(ha.slave),
        .mdc_o(mdc_a), .mdio_o(mdio_a), .mdio_oe_o(oe_a), .mdio_i(mdi_a)
    );

    eth_mdio_ctrl #(.CLK_DIV(DB), .PREAMBLE_BITS(PB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .host(hb.slave),
        .mdc_o(mdc_b), .mdio_o(mdio_b), .mdio_oe_o(oe_b), .mdio_i(mdi_b)
    );

    // Line monitors: bits seen at each MDC rising edge.
    logic [63:0] bits_a = '0, oes_a = '0, bits_b = '0, oes_b = '0;
    int nrise_a = 0, nrise_b = 0;
    int base_a = 0, base_b = 0;
    logic ta2_a = 1'b0, ta2_b = 1'b0;
    logic [15:0] pd_a = '0, pd_b = '0;

    function automatic logic phy_bit(int k, int p, logic ta2,
                                     logic [15:0] d);
        if (k == p + 15) return ta2;
        if (k >= p + 16 && k < p + 32) return d[15 - (k - p - 16)];
        return 1'b1;
    endfunction

    always @(posedge mdc_a) begin
        bits_a = {bits_a[62:0], mdio_a};
        oes_a = {oes_a[62:0], oe_a};
        nrise_a = nrise_a + 1;
    end
    always @(posedge mdc_b) begin
        bits_b = {bits_b[62:0], mdio_b};
        oes_b = {oes_b[62:0], oe_b};
        nrise_b = nrise_b + 1;
    end
    // PHY presents bit k after the falling edge that follows k rises.
    always @(negedge mdc_a) mdi_a = phy_bit(nrise_a - base_a, PA, ta2_a, pd_a);
    always @(negedge mdc_b) mdi_b = phy_bit(nrise_b - base_b, PB, ta2_b, pd_b);

    function automatic logic [63:0] ones(int k);
        if (k >= 64) return '1;
        return (64'd1 << k) - 64'd1;
    endfunction

    function automatic logic [63:0] exp_frame(int p, logic wr,
        logic [4:0] phy, logic [4:0] rg, logic [15:0] wd);
        logic [63:0] f;
        f = ones(p);
        f = {f[31:0], 2'b01, (wr ? 2'b01 : 2'b10), phy, rg,
             (wr ? 2'b10 : 2'b11), (wr ? wd : 16'hFFFF)};
        return f;
    endfunction

    function automatic logic [63:0] exp_oe(int p, logic wr);
        return wr ? ones(p + 32) : (ones(p + 14) << 18);
    endfunction

    function automatic int exp_lat(int sel);
        return sel == 0 ? (PA + 32) * 2 * DA + 1 : (PB + 32) * 2 * DB + 1;
    endfunction

    // {ready, valid, busy, error, rdata}
    function automatic logic [19:0] g_rsp(int sel);
        if (sel == 0)
            return {ha.req_ready_o, ha.rsp_valid_o, ha.busy_o,
                    ha.rsp_error_o, ha.rsp_rdata_o};
        return {hb.req_ready_o, hb.rsp_valid_o, hb.busy_o,
                hb.rsp_error_o, hb.rsp_rdata_o};
    endfunction

    function automatic logic [2:0] g_pins(int sel);
        return sel == 0 ? {mdc_a, mdio_a, oe_a} : {mdc_b, mdio_b, oe_b};
    endfunction

    task automatic set_req(input int sel, input logic v, input logic wr,
        input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        if (sel == 0) begin
            ha.req_valid_i = v; ha.req_write_i = wr;
            ha.req_phy_addr_i = phy; ha.req_reg_addr_i = rg;
            ha.req_wdata_i = wd;
        end else begin
            hb.req_valid_i = v; hb.req_write_i = wr;
            hb.req_phy_addr_i = phy; hb.req_reg_addr_i = rg;
            hb.req_wdata_i = wd;
        end
    endtask

    task automatic arm_phy(input int sel, input logic ta2,
                           input logic [15:0] pd);
        if (sel == 0) begin base_a = nrise_a; ta2_a = ta2; pd_a = pd; end
        else begin base_b = nrise_b; ta2_b = ta2; pd_b = pd; end
    endtask

    task automatic run_txn(input int sel, input logic wr,
        input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
        input logic ta2, input logic [15:0] pd,
        output int lat, output logic [19:0] r_first,
        output logic [19:0] r_done, output logic [19:0] r_after,
        output logic [63:0] bits, output logic [63:0] oes,
        output int nbits);
        logic [19:0] r;
        int lim;
        lim = 2 * exp_lat(sel);
        @(negedge clk);
        arm_phy(sel, ta2, pd);
        set_req(sel, 1'b1, wr, phy, rg, wd);
        @(posedge clk); #1;
        set_req(sel, 1'b0, wr, phy, rg, wd);
        lat = 1;
        r_first = g_rsp(sel);
        r = r_first;
        while (!r[18] && lat < lim) begin
            @(posedge clk); #1;
            lat++;
            r = g_rsp(sel);
        end
        r_done = r;
        bits = sel == 0 ? bits_a : bits_b;
        oes = sel == 0 ? oes_a : oes_b;
        nbits = sel == 0 ? nrise_a - base_a : nrise_b - base_b;
        @(posedge clk); #1;
        r_after = g_rsp(sel);
    endtask

    task automatic test_reset();
        logic [19:0] r;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            r = g_rsp(s);
            total++;
            if (r[17] !== 1'b0) $display("FAIL rst_busy s%0d got %b want 0", s, r[17]);
            else pass_cnt++;
            total++;
            if (r[18] !== 1'b0) $display("FAIL rst_valid s%0d got %b want 0", s, r[18]);
            else pass_cnt++;
            total++;
            if (r[16:0] !== 17'h0) $display("FAIL rst_rsp s%0d got %h want 0", s, r[16:0]);
            else pass_cnt++;
            total++;
            if (g_pins(s) !== 3'b010) $display("FAIL rst_pins s%0d got %b want 010", s, g_pins(s));
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            r = g_rsp(s);
            total++;
            if (r[19] !== 1'b1) $display("FAIL rst_ready s%0d got %b want 1", s, r[19]);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_ref();
        int lat, nb;
        logic [19:0] rf, rd, ra;
        logic [63:0] bits, oes;
        run_txn(0, 1'b1, 5'd1, 5'd0, 16'h1140, 1'b1, 16'hFFFF,
                lat, rf, rd, ra, bits, oes, nb);
        total++;
        if (lat !== 257) $display("FAIL wr_latency got %0d want 257", lat);
        else pass_cnt++;
        total++;
        if (bits !== 64'hFFFFFFFF_5082_1140) $display("FAIL wr_stream got %h want FFFFFFFF50821140", bits);
        else pass_cnt++;
        total++;
        if (oes !== '1 || nb !== 64) $display("FAIL wr_oe got %h/%0d want all-ones/64", oes, nb);
        else pass_cnt++;
        total++;
        if (rd[16:0] !== 17'h0) $display("FAIL wr_rsp got %h want 0", rd[16:0]);
        else pass_cnt++;
        total++;
        if (rf[19:17] !== 3'b001) $display("FAIL wr_busy_first got %b want 001", rf[19:17]);
        else pass_cnt++;
        total++;
        if (ra[19:17] !== 3'b100) $display("FAIL wr_after got %b want 100", ra[19:17]);
        else pass_cnt++;
    endtask

    task automatic test_read(input string nm, input logic ta2,
                             input logic [15:0] pd);
        int lat, nb;
        logic [19:0] rf, rd, ra;
        logic [63:0] bits, oes, m, ef;
        run_txn(0, 1'b0, 5'd3, 5'd2, 16'h0, ta2, pd,
                lat, rf, rd, ra, bits, oes, nb);
        m = exp_oe(PA, 1'b0);
        ef = exp_frame(PA, 1'b0, 5'd3, 5'd2, 16'h0);
        total++;
        if ((bits & m) !== (ef & m)) $display("FAIL %s_hdr got %h want %h", nm, bits & m, ef & m);
        else pass_cnt++;
        total++;
        if (oes !== m) $display("FAIL %s_oe got %h want %h", nm, oes, m);
        else pass_cnt++;
        total++;
        if (rd[15:0] !== pd) $display("FAIL %s_rdata got %h want %h", nm, rd[15:0], pd);
        else pass_cnt++;
        total++;
        if (rd[16] !== ta2) $display("FAIL %s_err got %b want %b", nm, rd[16], ta2);
        else pass_cnt++;
        total++;
        if (ra[16:0] !== {ta2, pd} || ra[18] !== 1'b0)
            $display("FAIL %s_hold got %h want %h", nm, ra[16:0], {ta2, pd});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [19:0] r;
        int pulses;
        int lat, nb;
        logic [19:0] rf, rd, ra;
        logic [63:0] bits, oes;
        @(negedge clk);
        arm_phy(0, 1'b0, 16'h1234);
        set_req(0, 1'b1, 1'b0, 5'd2, 5'd4, 16'h0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 5'd2, 5'd4, 16'h0);
        repeat (209) @(posedge clk);
        #1;
        total++;
        if (g_pins(0)[0] !== 1'b0 || g_rsp(0)[17] !== 1'b1)
            $display("FAIL mid_data got pins %b busy %b want oe 0 busy 1", g_pins(0), g_rsp(0)[17]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        r = g_rsp(0);
        total++;
        if (g_pins(0) !== 3'b010) $display("FAIL mid_pins got %b want 010", g_pins(0));
        else pass_cnt++;
        total++;
        if (r[18:0] !== 19'h0) $display("FAIL mid_rsp got %h want 0", r[18:0]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (300) begin
            @(posedge clk); #1;
            r = g_rsp(0);
            if (r[18]) pulses++;
        end
        total++;
        if (pulses !== 0) $display("FAIL mid_no_pulse got %0d want 0", pulses);
        else pass_cnt++;
        run_txn(0, 1'b0, 5'd9, 5'd17, 16'h0, 1'b0, 16'h5A3C,
                lat, rf, rd, ra, bits, oes, nb);
        total++;
        if (lat !== exp_lat(0) || rd[16:0] !== 17'h05A3C)
            $display("FAIL mid_after got %0d/%h want %0d/05a3c", lat, rd[16:0], exp_lat(0));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int dn[$];
        logic [19:0] r;
        int g1, g2, g3;
        @(negedge clk);
        arm_phy(0, 1'b1, 16'hFFFF);
        set_req(0, 1'b1, 1'b1, 5'd7, 5'd9, 16'h55AA);
        for (int t = 0; t < 800; t++) begin
            r = g_rsp(0);
            if (r[18]) dn.push_back(t);
            if (r[19] && ha.req_valid_i) acc.push_back(t);
            @(negedge clk);
            if (acc.size() == 2 && ha.req_valid_i)
                set_req(0, 1'b0, 1'b1, 5'd7, 5'd9, 16'h55AA);
        end
        total++;
        if (acc.size() != 2 || dn.size() != 2)
            $display("FAIL b2b_count got %0d/%0d want 2/2", acc.size(), dn.size());
        else pass_cnt++;
        g1 = -1; g2 = -1; g3 = -1;
        if (acc.size() >= 2 && dn.size() >= 2) begin
            g1 = dn[0] - acc[0];
            g2 = acc[1] - dn[0];
            g3 = dn[1] - acc[1];
        end
        total++;
        if (g1 !== 257 || g3 !== 257) $display("FAIL b2b_lat got %0d/%0d want 257/257", g1, g3);
        else pass_cnt++;
        total++;
        if (g2 !== 1) $display("FAIL b2b_gap got %0d want 1", g2);
        else pass_cnt++;
        total++;
        if (ha.rsp_rdata_o !== 16'h0 || ha.rsp_error_o !== 1'b0)
            $display("FAIL b2b_rsp got %h/%b want 0000/0", ha.rsp_rdata_o, ha.rsp_error_o);
        else pass_cnt++;
    endtask

    task automatic test_frame_b();
        int lat, nb;
        logic [19:0] rf, rd, ra;
        logic [63:0] bits, oes, ef;
        run_txn(1, 1'b1, 5'd21, 5'd6, 16'hBEEF, 1'b1, 16'hFFFF,
                lat, rf, rd, ra, bits, oes, nb);
        ef = exp_frame(PB, 1'b1, 5'd21, 5'd6, 16'hBEEF);
        total++;
        if (lat !== 65) $display("FAIL nopre_latency got %0d want 65", lat);
        else pass_cnt++;
        total++;
        if (bits[31:30] !== 2'b01 || nb !== 32)
            $display("FAIL nopre_start got %b/%0d want 01/32", bits[31:30], nb);
        else pass_cnt++;
        total++;
        if (bits[31:0] !== ef[31:0]) $display("FAIL nopre_stream got %h want %h", bits[31:0], ef[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, nb, sel, p;
        logic wr, ta2;
        logic [4:0] phy, rg;
        logic [15:0] wd, pd, er;
        logic [19:0] rf, rd, ra;
        logic [63:0] bits, oes, m, w, ef;
        for (int i = 0; i < 6; i++) begin
            sel = i % 2;
            p = sel == 0 ? PA : PB;
            wr = 1'($urandom_range(0, 1));
            ta2 = 1'($urandom_range(0, 1));
            phy = 5'($urandom);
            rg = 5'($urandom);
            wd = 16'($urandom);
            pd = 16'($urandom);
            run_txn(sel, wr, phy, rg, wd, ta2, pd,
                    lat, rf, rd, ra, bits, oes, nb);
            m = exp_oe(p, wr);
            w = ones(p + 32);
            ef = exp_frame(p, wr, phy, rg, wd);
            er = wr ? 16'h0 : pd;
            total++;
            if (lat !== exp_lat(sel)) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, exp_lat(sel));
            else pass_cnt++;
            total++;
            if (nb !== p + 32) $display("FAIL rnd%0d_nbits got %0d want %0d", i, nb, p + 32);
            else pass_cnt++;
            total++;
            if ((bits & m) !== (ef & m)) $display("FAIL rnd%0d_stream got %h want %h", i, bits & m, ef & m);
            else pass_cnt++;
            total++;
            if ((oes & w) !== m) $display("FAIL rnd%0d_oe got %h want %h", i, oes & w, m);
            else pass_cnt++;
            total++;
            if (rd[15:0] !== er) $display("FAIL rnd%0d_rdata got %h want %h", i, rd[15:0], er);
            else pass_cnt++;
            total++;
            if (rd[16] !== (!wr && ta2)) $display("FAIL rnd%0d_err got %b want %b", i, rd[16], !wr && ta2);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write_ref();
        test_read("rd_phy", 1'b0, 16'hABCD);
        test_read("rd_nophy", 1'b1, 16'hFFFF);
        test_reset_mid();
        test_back_to_back();
        test_frame_b();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
